// File: rtl/uart_cmd_arbiter_pkg.sv
// Shared constants and helpers for the UART command arbiter slice.
package uart_cmd_arbiter_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned MAX_CH      = 8;
    localparam int unsigned BUS_W       = MAX_CH * BYTE_W;
    localparam int unsigned DEF_NUM_CH  = 4;
    localparam int unsigned DEF_DEPTH   = 8;
    localparam int unsigned DEF_REFRESH = 0;

    // Extract channel idx's byte from a zero-extended channel bus.
    function automatic logic [BYTE_W-1:0] ch_slice(input logic [BUS_W-1:0] bus,
                                                    input logic [2:0]       idx);
        logic [5:0] base;
        base = {idx, 3'b000};
        return bus[base +: BYTE_W];
    endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO; push and pop may coincide at any occupancy, including full.
module sync_byte_fifo
    import uart_cmd_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [BYTE_W-1:0]          push_data,
    input  logic                       pop,
    output logic [BYTE_W-1:0]          pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
            else if (pop_ok && !push_ok) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_cmd_arbiter.sv
// Detects per-channel command byte changes, arbitrates round-robin and queues bytes for the UART.
module uart_cmd_arbiter
    import uart_cmd_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CH  = DEF_NUM_CH,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned REFRESH = DEF_REFRESH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CH*BYTE_W-1:0]   ch_data,
    input  logic [NUM_CH-1:0]          ch_en,
    input  logic                       hold,
    output logic [BYTE_W-1:0]          tx_bits,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [NUM_CH-1:0]          pending,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [BUS_W-1:0]  data_ext;
    logic [BYTE_W-1:0] snap [NUM_CH];
    logic [NUM_CH-1:0] snap_valid;
    logic [NUM_CH-1:0] change;
    logic [NUM_CH-1:0] pend_next;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_found;
    logic              grant;
    logic [BYTE_W-1:0] gnt_byte;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              refresh_hit;

    assign data_ext = BUS_W'(ch_data);
    assign pop      = tx_ready && !fifo_empty;
    assign tx_valid = !fifo_empty;
    assign gnt_byte = ch_slice(data_ext, 3'(gnt_idx));
    assign grant    = !hold && gnt_found && (!fifo_full || pop);

    always_comb begin
        change = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            change[i] = ch_en[i] && (!snap_valid[i] || (ch_slice(data_ext, 3'(i)) != snap[i]));
        end
    end

    // Round-robin search starting at the channel after the last grant.
    always_comb begin
        int unsigned idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned off = 0; off < NUM_CH; off++) begin
            idx = (32'(rr_ptr) + off) % NUM_CH;
            if (!gnt_found && pending[CH_W'(idx)]) begin
                gnt_found = 1'b1;
                gnt_idx   = CH_W'(idx);
            end
        end
    end

    // The granted channel's snapshot takes the pushed byte, so its change is absorbed by the grant.
    always_comb begin
        pend_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant && (gnt_idx == CH_W'(i))) begin
                pend_next[i] = ch_en[i] && refresh_hit;
            end else begin
                pend_next[i] = ch_en[i] && (pending[i] || change[i] || refresh_hit);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending    <= '0;
            snap_valid <= '0;
            rr_ptr     <= '0;
        end else begin
            pending <= pend_next;
            if (grant) begin
                snap_valid[gnt_idx] <= 1'b1;
                rr_ptr <= (32'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + CH_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (grant) snap[gnt_idx] <= gnt_byte;
    end

    generate
        if (REFRESH > 0) begin : g_refresh
            localparam int unsigned RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
            logic [RW-1:0] ref_cnt;

            assign refresh_hit = (32'(ref_cnt) == REFRESH - 1);

            always_ff @(posedge clock) begin
                if (reset || refresh_hit) ref_cnt <= '0;
                else                      ref_cnt <= ref_cnt + RW'(1);
            end
        end else begin : g_no_refresh
            assign refresh_hit = 1'b0;
        end
    endgenerate

    sync_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (grant),
        .push_data (gnt_byte),
        .pop       (pop),
        .pop_data  (tx_bits),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_uart_cmd_arbiter.sv
// Directed bench for uart_cmd_arbiter: default, shallow-FIFO and keep-alive configurations.
module tb_uart_cmd_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: defaults (DEPTH=8, REFRESH=0)
    logic        a_reset, a_hold, a_tx_ready, a_tx_valid;
    logic [31:0] a_ch_data;
    logic [3:0]  a_ch_en, a_pending, a_fifo_count;
    logic [7:0]  a_tx_bits;

    // Instance B: DEPTH=2
    logic        b_reset, b_hold, b_tx_ready, b_tx_valid;
    logic [31:0] b_ch_data;
    logic [3:0]  b_ch_en, b_pending;
    logic [1:0]  b_fifo_count;
    logic [7:0]  b_tx_bits;

    // Instance C: REFRESH=100
    logic        c_reset, c_hold, c_tx_ready, c_tx_valid;
    logic [31:0] c_ch_data;
    logic [3:0]  c_ch_en, c_pending, c_fifo_count;
    logic [7:0]  c_tx_bits;

    uart_cmd_arbiter u_a (
        .clock(clk), .reset(a_reset), .ch_data(a_ch_data), .ch_en(a_ch_en), .hold(a_hold),
        .tx_bits(a_tx_bits), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
        .pending(a_pending), .fifo_count(a_fifo_count)
    );

    uart_cmd_arbiter #(.DEPTH(2)) u_b (
        .clock(clk), .reset(b_reset), .ch_data(b_ch_data), .ch_en(b_ch_en), .hold(b_hold),
        .tx_bits(b_tx_bits), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
        .pending(b_pending), .fifo_count(b_fifo_count)
    );

    uart_cmd_arbiter #(.REFRESH(100)) u_c (
        .clock(clk), .reset(c_reset), .ch_data(c_ch_data), .ch_en(c_ch_en), .hold(c_hold),
        .tx_bits(c_tx_bits), .tx_valid(c_tx_valid), .tx_ready(c_tx_ready),
        .pending(c_pending), .fifo_count(c_fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_pulse();
        a_tx_ready = 1'b1;
        tick();
        a_tx_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_b [4];
        logic [7:0] exp_a [3];
        int         seen [$];

        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_a = '{8'h77, 8'h35, 8'hA1};

        a_reset = 1'b1; a_hold = 1'b0; a_tx_ready = 1'b0; a_ch_en = 4'b0011; a_ch_data = 32'h0000_1205;
        b_reset = 1'b1; b_hold = 1'b0; b_tx_ready = 1'b0; b_ch_en = 4'b1111; b_ch_data = 32'h4433_2211;
        c_reset = 1'b1; c_hold = 1'b0; c_tx_ready = 1'b1; c_ch_en = 4'b0001; c_ch_data = 32'h0000_005A;
        tick(); tick();

        chk("rst_valid", 32'(a_tx_valid), 0);
        chk("rst_bits", 32'(a_tx_bits), 0);
        chk("rst_pending", 32'(a_pending), 0);
        chk("rst_count", 32'(a_fifo_count), 0);

        // Two enabled channels send once each after reset, in channel order
        a_reset = 1'b0;
        tick();
        chk("boot_pend", 32'(a_pending), 32'h3);
        chk("boot_valid0", 32'(a_tx_valid), 0);
        tick();
        chk("boot_valid1", 32'(a_tx_valid), 1);
        chk("boot_bits0", 32'(a_tx_bits), 32'h05);
        chk("boot_pend1", 32'(a_pending), 32'h2);
        tick();
        chk("boot_count2", 32'(a_fifo_count), 2);
        chk("boot_head_stable", 32'(a_tx_bits), 32'h05);
        chk("boot_pend2", 32'(a_pending), 0);
        a_pulse();
        chk("boot_bits1", 32'(a_tx_bits), 32'h12);
        chk("boot_count1", 32'(a_fifo_count), 1);
        a_pulse();
        chk("boot_empty", 32'(a_tx_valid), 0);
        chk("boot_empty_bits", 32'(a_tx_bits), 0);
        a_pulse();
        chk("ready_on_empty", 32'(a_fifo_count), 0);
        tick(); tick(); tick();
        chk("idle_valid", 32'(a_tx_valid), 0);
        chk("idle_pend", 32'(a_pending), 0);

        // Enable ch2 with 0xA0: visible two edges later
        a_ch_en = 4'b0111; a_ch_data = 32'h00A0_1205;
        tick();
        chk("ch2_pend", 32'(a_pending), 32'h4);
        chk("ch2_valid0", 32'(a_tx_valid), 0);
        tick();
        chk("ch2_valid1", 32'(a_tx_valid), 1);
        chk("ch2_bits", 32'(a_tx_bits), 32'hA0);
        a_pulse();
        chk("ch2_drain", 32'(a_fifo_count), 0);

        // Hold blocks grants; release gives one push
        a_hold = 1'b1; a_ch_data = 32'h00A0_3405;
        tick();
        chk("hold_pend", 32'(a_pending), 32'h2);
        tick(); tick();
        chk("hold_pend_kept", 32'(a_pending), 32'h2);
        chk("hold_no_push", 32'(a_fifo_count), 0);
        a_hold = 1'b0;
        tick();
        chk("unhold_count", 32'(a_fifo_count), 1);
        chk("unhold_bits", 32'(a_tx_bits), 32'h34);
        chk("unhold_pend", 32'(a_pending), 0);
        a_pulse();
        chk("unhold_drain", 32'(a_fifo_count), 0);

        // Disabling a channel drops its pending request
        a_hold = 1'b1; a_ch_data = 32'h00A0_3477;
        tick();
        chk("dis_pend_set", 32'(a_pending), 32'h1);
        a_ch_en = 4'b0110;
        tick();
        chk("dis_pend_clr", 32'(a_pending), 0);
        a_hold = 1'b0;
        tick();
        chk("dis_no_push", 32'(a_fifo_count), 0);

        // Queue three bytes (round-robin resumes after ch1), then reset mid-transfer
        a_hold = 1'b1; a_ch_en = 4'b0111; a_ch_data = 32'h00A1_3577;
        tick();
        chk("q3_pend", 32'(a_pending), 32'h7);
        a_hold = 1'b0;
        tick(); tick(); tick();
        chk("q3_count", 32'(a_fifo_count), 3);
        chk("q3_rr_head", 32'(a_tx_bits), 32'hA1);
        chk("q3_pend_clr", 32'(a_pending), 0);
        a_reset = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(a_tx_valid), 0);
        chk("mid_rst_count", 32'(a_fifo_count), 0);
        chk("mid_rst_pend", 32'(a_pending), 0);
        a_reset = 1'b0;
        tick(); tick(); tick(); tick();
        chk("resend_count", 32'(a_fifo_count), 3);
        chk("resend_pend", 32'(a_pending), 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("resend_byte%0d", i), 32'(a_tx_bits), 32'(exp_a[i]));
            a_pulse();
        end
        tick(); tick(); tick(); tick(); tick();
        chk("resend_once_valid", 32'(a_tx_valid), 0);
        chk("resend_once_count", 32'(a_fifo_count), 0);

        // DEPTH=2: four channels change at once, back-pressure held in pending
        b_reset = 1'b0;
        tick();
        chk("b_pend_all", 32'(b_pending), 32'hF);
        tick(); tick(); tick();
        chk("b_full_count", 32'(b_fifo_count), 2);
        chk("b_pend_wait", 32'(b_pending), 32'hC);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b_byte%0d", i), 32'(b_tx_bits), 32'(exp_b[i]));
            b_tx_ready = 1'b1;
            tick();
            b_tx_ready = 1'b0;
            if (i == 0) begin
                chk("b_push_pop_full", 32'(b_fifo_count), 2);
                chk("b_pend_after", 32'(b_pending), 32'h8);
            end
            tick();
        end
        chk("b_drained", 32'(b_fifo_count), 0);
        chk("b_valid_end", 32'(b_tx_valid), 0);
        chk("b_pend_end", 32'(b_pending), 0);

        // REFRESH=100: ch0 byte re-sent every 100 cycles
        c_reset = 1'b0;
        for (int n = 1; n <= 250; n++) begin
            tick();
            if (c_tx_valid) begin
                seen.push_back(n);
                chk($sformatf("c_bits_at%0d", n), 32'(c_tx_bits), 32'h5A);
            end
        end
        chk("c_sends", 32'(seen.size()), 3);
        if (seen.size() == 3) begin
            chk("c_first", 32'(seen[0]), 2);
            chk("c_second", 32'(seen[1]), 101);
            chk("c_third", 32'(seen[2]), 201);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
